// File: rtl/uart_tx_queue_if.sv
// Host-write / transmitter-handshake bundle for uart_tx_queue.
// UART_TXQ_FLUSH_EN adds the host-side flush strobe.
interface uart_tx_queue_if #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             ovf_clr;
    logic [WIDTH-1:0] dintx;
    logic             newd;
    logic             donetx;
`ifdef UART_TXQ_FLUSH_EN
    logic             flush;

    modport master (
        output wr_en, wr_data, ovf_clr, donetx, flush,
        input  full, empty, count, overflow, dintx, newd
    );
    modport slave (
        input  wr_en, wr_data, ovf_clr, donetx, flush,
        output full, empty, count, overflow, dintx, newd
    );
`else
    modport master (
        output wr_en, wr_data, ovf_clr, donetx,
        input  full, empty, count, overflow, dintx, newd
    );
    modport slave (
        input  wr_en, wr_data, ovf_clr, donetx,
        output full, empty, count, overflow, dintx, newd
    );
`endif
endinterface

// File: rtl/uart_tx_queue.sv
// Circular byte FIFO feeding the UART transmitter one frame at a time.
// Optional feature: define UART_TXQ_FLUSH_EN to add a synchronous queue flush.
module uart_tx_queue #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int HOLD  = 128
) (
    input logic           clk,
    input logic           rst,
    uart_tx_queue_if.slave q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_r;
    logic             overflow_r;
    logic [WIDTH-1:0] dintx_r;
    logic             newd_r;
    logic             donetx_q;
    logic [HW-1:0]    hold_cnt;

    logic pop;
    logic wr_accept;
    logic wr_drop;
    logic flush_req;
    logic donetx_rise;

`ifdef UART_TXQ_FLUSH_EN
    assign flush_req = q.flush;
`else
    assign flush_req = 1'b0;
`endif

    // A full queue still takes a write on the cycle its head is popped.
    assign pop         = (state == IDLE) && (count_r != '0);
    assign wr_accept   = q.wr_en && !flush_req && ((count_r != FULL_CNT) || pop);
    assign wr_drop     = q.wr_en && !flush_req && !wr_accept;
    assign donetx_rise = q.donetx && !donetx_q;

    // NOTE: storage is deliberately left out of reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (wr_accept) mem[wr_ptr] <= q.wr_data;
    end

    // NOTE: all sequential state uses non-blocking assignments so every block samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
        end else if (flush_req) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)       rd_ptr <= rd_ptr + 1'b1;
            case ({wr_accept, pop})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: ;
            endcase
        end
    end

    // A dropped write outranks a same-cycle clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                         overflow_r <= 1'b0;
        else if (wr_drop)                 overflow_r <= 1'b1;
        else if (q.ovf_clr || flush_req)  overflow_r <= 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            dintx_r  <= '0;
            newd_r   <= 1'b0;
            donetx_q <= 1'b0;
        end else begin
            donetx_q <= q.donetx;
            case (state)
                IDLE: begin
                    if (pop) begin
                        dintx_r  <= mem[rd_ptr];
                        hold_cnt <= HOLD_LOAD;
                        newd_r   <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (hold_cnt == '0) begin
                        newd_r <= 1'b0;
                        state  <= WAIT;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                WAIT: begin
                    if (donetx_rise) state <= IDLE;
                end
                default: begin
                    newd_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign q.full     = (count_r == FULL_CNT);
    assign q.empty    = (count_r == '0);
    assign q.count    = count_r;
    assign q.overflow = overflow_r;
    assign q.dintx    = dintx_r;
    assign q.newd     = newd_r;
endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue: reset, issue timing, ordering, full/overflow, reset and flush.
`timescale 1ns/1ps
module tb_uart_tx_queue;
    localparam int DEPTH = 16;
    localparam int WIDTH = 8;
    localparam int HOLD  = 128;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    uart_tx_queue_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    uart_tx_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH), .HOLD(HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .q   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wr_byte(input logic [7:0] b);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_newd(input logic lvl, input int bound, input string tag);
        int n;
        n = 0;
        while (bus.newd !== lvl && n < bound) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (bus.newd !== lvl) begin
            fails++;
            $display("FAIL %s: newd=%b want %b after %0d cycles", tag, bus.newd, lvl, n);
        end
    endtask

    // Produce one donetx rising edge; returns at the negedge after the edge was sampled.
    task automatic done_edge;
        bus.donetx = 1'b0;
        @(negedge clk);
        bus.donetx = 1'b1;
        @(negedge clk);
        bus.donetx = 1'b0;
    endtask

    task automatic test_reset;
        rst         = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.ovf_clr = 1'b0;
        bus.donetx  = 1'b0;
`ifdef UART_TXQ_FLUSH_EN
        bus.flush   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        tests++;
        if ({bus.full, bus.empty, bus.overflow, bus.newd} !== 4'b0100) begin
            fails++;
            $display("FAIL reset_flags: got full/empty/ovf/newd=%b want 0100",
                     {bus.full, bus.empty, bus.overflow, bus.newd});
        end
        tests++;
        if (bus.count !== 5'd0 || bus.dintx !== 8'h00) begin
            fails++;
            $display("FAIL reset_data: got count=%0d dintx=%h want 0 00", bus.count, bus.dintx);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_byte;
        int hi;
        int n;
        logic stable;
        wr_byte(8'hA5);
        tests++;
        if (bus.count !== 5'd1 || bus.empty !== 1'b0 || bus.newd !== 1'b0) begin
            fails++;
            $display("FAIL single_write: got count=%0d empty=%b newd=%b want 1 0 0",
                     bus.count, bus.empty, bus.newd);
        end
        @(negedge clk);
        tests++;
        if (bus.newd !== 1'b1 || bus.count !== 5'd0 || bus.dintx !== 8'hA5) begin
            fails++;
            $display("FAIL single_issue: got newd=%b count=%0d dintx=%h want 1 0 a5",
                     bus.newd, bus.count, bus.dintx);
        end
        hi = 1;
        n = 0;
        stable = 1'b1;
        while (bus.newd === 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
            if (bus.newd === 1'b1) hi++;
            if (bus.dintx !== 8'hA5) stable = 1'b0;
        end
        tests++;
        if (hi != HOLD) begin
            fails++;
            $display("FAIL single_hold: got %0d newd cycles want %0d", hi, HOLD);
        end
        tests++;
        if (stable !== 1'b1) begin
            fails++;
            $display("FAIL single_dintx_stable: got changing dintx want constant a5");
        end
        // donetx rises and stays high; a following write must still issue after one cycle.
        bus.donetx = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.empty !== 1'b1 || bus.newd !== 1'b0) begin
            fails++;
            $display("FAIL single_done: got empty=%b newd=%b want 1 0", bus.empty, bus.newd);
        end
        wr_byte(8'h3C);
        @(negedge clk);
        tests++;
        if (bus.newd !== 1'b1 || bus.dintx !== 8'h3C) begin
            fails++;
            $display("FAIL single_reissue: got newd=%b dintx=%h want 1 3c", bus.newd, bus.dintx);
        end
        wait_newd(1'b0, 300, "single_window2");
        done_edge();
        repeat (3) @(negedge clk);
        tests++;
        if (bus.empty !== 1'b1 || bus.newd !== 1'b0) begin
            fails++;
            $display("FAIL single_idle: got empty=%b newd=%b want 1 0", bus.empty, bus.newd);
        end
    endtask

    task automatic test_burst;
        int hi;
        int n;
        for (int i = 0; i < 5; i++) wr_byte(8'(i + 1));
        tests++;
        if (bus.count !== 5'd4 || bus.newd !== 1'b1 || bus.dintx !== 8'h01) begin
            fails++;
            $display("FAIL burst_fill: got count=%0d newd=%b dintx=%h want 4 1 01",
                     bus.count, bus.newd, bus.dintx);
        end
        for (int i = 0; i < 5; i++) begin
            wait_newd(1'b1, 4, "burst_issue");
            tests++;
            if (bus.dintx !== 8'(i + 1)) begin
                fails++;
                $display("FAIL burst_order: got dintx=%h want %h", bus.dintx, 8'(i + 1));
            end
            hi = 0;
            n = 0;
            while (bus.newd === 1'b1 && n < 400) begin
                hi++;
                // A donetx edge during ISSUE must be ignored.
                if (i == 1 && hi == 60) bus.donetx = 1'b1;
                if (i == 1 && hi == 61) bus.donetx = 1'b0;
                @(negedge clk);
                n++;
            end
            if (i > 0) begin
                tests++;
                if (hi != HOLD) begin
                    fails++;
                    $display("FAIL burst_hold: frame %0d got %0d cycles want %0d", i, hi, HOLD);
                end
            end
            if (i == 1) begin
                repeat (5) @(negedge clk);
                tests++;
                if (bus.newd !== 1'b0) begin
                    fails++;
                    $display("FAIL burst_issue_edge_ignored: got newd=%b want 0", bus.newd);
                end
            end
            done_edge();
            tests++;
            if (bus.newd !== 1'b0) begin
                fails++;
                $display("FAIL burst_gap: got newd=%b want 0", bus.newd);
            end
            @(negedge clk);
            tests++;
            if (bus.newd !== (i < 4)) begin
                fails++;
                $display("FAIL burst_next: frame %0d got newd=%b want %b", i, bus.newd, (i < 4));
            end
        end
        tests++;
        if (bus.empty !== 1'b1 || bus.count !== 5'd0) begin
            fails++;
            $display("FAIL burst_drained: got empty=%b count=%0d want 1 0", bus.empty, bus.count);
        end
    endtask

    task automatic test_full_overflow;
        for (int i = 0; i < 17; i++) wr_byte(8'h10 + 8'(i));
        tests++;
        if (bus.count !== 5'd16 || bus.full !== 1'b1 || bus.overflow !== 1'b0 ||
            bus.dintx !== 8'h10 || bus.newd !== 1'b1) begin
            fails++;
            $display("FAIL full_fill: got count=%0d full=%b ovf=%b dintx=%h newd=%b want 16 1 0 10 1",
                     bus.count, bus.full, bus.overflow, bus.dintx, bus.newd);
        end
        wr_byte(8'h99);
        tests++;
        if (bus.overflow !== 1'b1 || bus.count !== 5'd16) begin
            fails++;
            $display("FAIL full_drop: got ovf=%b count=%0d want 1 16", bus.overflow, bus.count);
        end
        bus.ovf_clr = 1'b1;
        wr_byte(8'h98);
        bus.ovf_clr = 1'b0;
        tests++;
        if (bus.overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_set_wins: got ovf=%b want 1", bus.overflow);
        end
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        tests++;
        if (bus.overflow !== 1'b0) begin
            fails++;
            $display("FAIL ovf_clr: got ovf=%b want 0", bus.overflow);
        end
    endtask

    task automatic test_simul_write_pop;
        logic [7:0] exp;
        wait_newd(1'b0, 300, "simul_window");
        bus.donetx = 1'b1;
        @(negedge clk);
        wr_byte(8'hEE);
        tests++;
        if (bus.count !== 5'd16 || bus.full !== 1'b1 || bus.overflow !== 1'b0 ||
            bus.newd !== 1'b1 || bus.dintx !== 8'h11) begin
            fails++;
            $display("FAIL simul_pop_write: got count=%0d full=%b ovf=%b newd=%b dintx=%h want 16 1 0 1 11",
                     bus.count, bus.full, bus.overflow, bus.newd, bus.dintx);
        end
        for (int k = 0; k < 16; k++) begin
            exp = (k < 15) ? 8'h12 + 8'(k) : 8'hEE;
            wait_newd(1'b0, 300, "drain_window");
            done_edge();
            @(negedge clk);
            tests++;
            if (bus.newd !== 1'b1 || bus.dintx !== exp || bus.count !== 5'(15 - k)) begin
                fails++;
                $display("FAIL drain_order: got newd=%b dintx=%h count=%0d want 1 %h %0d",
                         bus.newd, bus.dintx, bus.count, exp, 15 - k);
            end
        end
        wait_newd(1'b0, 300, "drain_last");
        done_edge();
        repeat (3) @(negedge clk);
        tests++;
        if (bus.newd !== 1'b0 || bus.empty !== 1'b1) begin
            fails++;
            $display("FAIL drain_empty: got newd=%b empty=%b want 0 1", bus.newd, bus.empty);
        end
    endtask

    task automatic test_reset_mid_frame;
        wr_byte(8'h5A);
        wr_byte(8'h6B);
        wr_byte(8'h7C);
        wait_newd(1'b0, 300, "rst_window");
        #2 rst = 1'b0;
        #1;
        tests++;
        if ({bus.full, bus.empty, bus.overflow, bus.newd} !== 4'b0100 ||
            bus.count !== 5'd0 || bus.dintx !== 8'h00) begin
            fails++;
            $display("FAIL async_reset: got flags=%b count=%0d dintx=%h want 0100 0 00",
                     {bus.full, bus.empty, bus.overflow, bus.newd}, bus.count, bus.dintx);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        wr_byte(8'hC3);
        @(negedge clk);
        tests++;
        if (bus.newd !== 1'b1 || bus.dintx !== 8'hC3 || bus.count !== 5'd0) begin
            fails++;
            $display("FAIL post_reset_issue: got newd=%b dintx=%h count=%0d want 1 c3 0",
                     bus.newd, bus.dintx, bus.count);
        end
        wait_newd(1'b0, 300, "post_reset_window");
        done_edge();
        repeat (3) @(negedge clk);
        tests++;
        if (bus.newd !== 1'b0 || bus.empty !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_idle: got newd=%b empty=%b want 0 1", bus.newd, bus.empty);
        end
    endtask

`ifdef UART_TXQ_FLUSH_EN
    task automatic test_flush;
        int hi;
        int n;
        for (int i = 0; i < 5; i++) wr_byte(8'h31 + 8'(i));
        bus.flush = 1'b1;
        wr_byte(8'h77);
        bus.flush = 1'b0;
        tests++;
        if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.overflow !== 1'b0 ||
            bus.newd !== 1'b1 || bus.dintx !== 8'h31) begin
            fails++;
            $display("FAIL flush_state: got count=%0d empty=%b ovf=%b newd=%b dintx=%h want 0 1 0 1 31",
                     bus.count, bus.empty, bus.overflow, bus.newd, bus.dintx);
        end
        hi = 5;
        n = 0;
        while (bus.newd === 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
            if (bus.newd === 1'b1) hi++;
        end
        tests++;
        if (hi != HOLD) begin
            fails++;
            $display("FAIL flush_window: got %0d newd cycles want %0d", hi, HOLD);
        end
        done_edge();
        repeat (5) @(negedge clk);
        tests++;
        if (bus.newd !== 1'b0 || bus.empty !== 1'b1) begin
            fails++;
            $display("FAIL flush_no_issue: got newd=%b empty=%b want 0 1", bus.newd, bus.empty);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_byte();
        test_burst();
        test_full_overflow();
        test_simul_write_pop();
        test_reset_mid_frame();
`ifdef UART_TXQ_FLUSH_EN
        test_flush();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Byte queue upstream of the UART transmitter in `uart_top`. Accepts bytes from a host write port at up to one byte per clock, buffers them in a circular FIFO, and hands them one at a time to the transmitter over its `dintx`/`newd`/`donetx` handshake. A new byte is issued only after the previous frame completes. It lets a host burst a message without pacing itself to the baud rate.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `WIDTH`, 8: data width; must match transmitter `dintx`.
- `HOLD`, 128: `clk` cycles `newd` is held high per issue; must be ≥ one transmitter bit-clock period and < one frame time.

Ports:
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `wr_en` input 1: host write strobe.
- `wr_data` input WIDTH: host byte; sampled when `wr_en` = 1.
- `full` output 1: `count` == DEPTH.
- `empty` output 1: `count` == 0.
- `count` output $clog2(DEPTH)+1: number of queued bytes, excluding the byte in flight.
- `overflow` output 1: sticky flag; set when a write is dropped.
- `ovf_clr` input 1: synchronous clear of `overflow`.
- `dintx` output WIDTH: byte presented to the transmitter.
- `newd` output 1: transmit request to the transmitter.
- `donetx` input 1: frame-complete indication from the transmitter. May stay high for many `clk` cycles; only its rising edge is used.

## Operation
- **FIFO:** `wr_ptr` and `rd_ptr` are $clog2(DEPTH) bits wide and wrap modulo DEPTH. The storage array is not reset.
- **Write:** accepted when `wr_en` and (`!full` or pop in the same cycle). Otherwise the byte is dropped and `overflow` is set.
- **Simultaneous write and pop:** both take effect; `count` is unchanged.
- **Overflow priority:** `ovf_clr` and a dropped write in the same cycle leave `overflow` = 1 (set wins).
- **FSM states:** IDLE, ISSUE, WAIT.
  - IDLE: if `!empty`, pop the head into the `dintx` register, load the hold counter with HOLD-1, and go to ISSUE.
  - ISSUE: `newd` = 1. Decrement the hold counter; at 0, go to WAIT.
  - WAIT: `newd` = 0. On a `donetx` rising edge (current 1, registered previous 0), go to IDLE.
- **`dintx` stability:** `dintx` holds its value from the pop until the next pop; it is stable throughout ISSUE and WAIT.
- **Edge detector:** the `donetx` edge register runs in every state. A `donetx` edge seen during ISSUE or IDLE is ignored.
- **Reset mid-frame:** the FSM returns to IDLE and the FIFO empties. The byte in flight is abandoned; the transmitter finishes it on its own.

## Timing
- **Reset values:** `full`=0, `empty`=1, `count`=0, `overflow`=0, `dintx`=0, `newd`=0; FSM in IDLE; edge register = 0.
- **Write to count:** a write at edge N shows in `count` and `empty` after edge N.
- **Issue latency from empty:** write at edge N → pop at edge N+1 → `newd` high from N+1 through N+HOLD (exactly HOLD cycles).
- **Back-to-back bytes:** after a `donetx` edge at edge M, the next byte pops at M+1. This gives one IDLE cycle between frames; `newd` is low in that cycle.
- **Count during pop:** `count` drops by 1 on the pop edge; the byte in flight is no longer counted.

## Configuration
- `UART_TXQ_FLUSH_EN` defined:
  - Adds input `flush` (1 bit).
  - When `flush` = 1, on the next edge: pointers and `count` go to 0 and `overflow` clears. A write in the same cycle is discarded and does not set `overflow`.
  - FSM and `dintx`/`newd` are untouched, so an in-flight byte completes normally.
- `UART_TXQ_FLUSH_EN` not defined: the port is absent and the queue drains only by transmission.

## Test plan
- **Reset and single byte:** reset, then write 0xA5 → `newd` high for exactly 128 cycles starting one cycle after the write, `dintx`=0xA5, `count` back to 0. Drive `donetx` → FSM returns to IDLE, `empty`=1.
- **Burst and ordering:** write 0x01..0x05 back-to-back → transmitted in order 0x01..0x05, one `newd` window per `donetx` edge, one-cycle gap between frames. With `tx` looped to `rx`, `doutrx` matches each byte.
- **Full and overflow:** with `donetx` held low, write 17 bytes with DEPTH=16 → first byte in flight, 16 queued, `full`=1. Write an 18th → dropped, `overflow`=1. `ovf_clr` → `overflow`=0.
- **Simultaneous write and pop at full:** write on the exact pop cycle → accepted, `count` stays 16, `overflow` stays 0.
- **Reset and flush mid-frame:** assert `rst` low during WAIT → all outputs return to reset values immediately (asynchronous). With `UART_TXQ_FLUSH_EN`, queue 4 bytes then pulse `flush` during ISSUE → `count`=0, current `newd` window completes, nothing further issued.
